mul_sequencer: RTL and testbench
================================

# mul_sequencer

Front-end sequencer for the repeated-addition multiplier core (controller plus datapath). It accepts operand pairs over a valid/ready interface and buffers them in a 2-entry FIFO. It drives the core's start/shared-data-bus protocol, waits for the core's done, and presents each product on a held valid/ready output. Zero operands bypass the core, and a watchdog converts a hung core into a flagged result.

## Interface
- W, 16, operand and product width; the product is truncated to W bits.
- TIMEOUT, 70000, maximum WAIT cycles before abort; must exceed 2^W + 8.
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO not full
- in_a  in  W  multiplicand
- in_b  in  W  multiplier (iteration count in the core)
- out_valid  out  1  result held
- out_ready  in  1  result consumed
- out_product  out  W  product
- out_timeout  out  1  result aborted by watchdog; out_product is 0
- mul_start  out  1  start pulse to core controller
- mul_data  out  W  shared data bus to core datapath
- mul_done  in  1  core finished; low from the cycle after start is sampled until the product is valid
- mul_product  in  W  core product register
- busy  out  1  FSM not IDLE, or FIFO non-empty, or out_valid

## Operation
- FIFO: 2 entries of {a,b}.
  - Push when in_valid && in_ready.
  - in_ready = (count < 2), depends only on count, never on in_valid.
  - At full, no push occurs even in a pop cycle.
  - Pop occurs only on the IDLE exit described below.
- FSM states: IDLE, START, LOADA, LOADB, WAIT.
- IDLE: when FIFO non-empty and out_valid == 0, pop the head into registers ra/rb.
  - If ra == 0 or rb == 0: load out_product = 0, out_timeout = 0, out_valid = 1; stay IDLE. The core is not engaged.
  - Else: go to START.
- START (1 cycle): mul_start = 1, mul_data = ra.
- LOADA (1 cycle): mul_start = 0, mul_data = ra.
- LOADB (1 cycle): mul_data = rb.
- WAIT: mul_data = rb held; watchdog counts cycles in WAIT from 0.
  - mul_done == 1: capture mul_product into out_product, out_timeout = 0, out_valid = 1 → IDLE.
  - Watchdog reaches TIMEOUT-1 without done: out_product = 0, out_timeout = 1, out_valid = 1 → IDLE.
  - If done and the timeout coincide, done wins.
- mul_done is sampled only in WAIT and is ignored in all other states.
- mul_data is 0 in IDLE.
- Output register: out_valid is held until out_ready is sampled high. out_product and out_timeout are stable while out_valid is high. out_valid clears on the handshake edge.
- A new operation cannot start in the same cycle as an output handshake; IDLE needs out_valid == 0 at the edge.

## Timing
- Reset (async, any state): FIFO empty, FSM IDLE, watchdog 0, ra/rb 0.
- Output values during and after reset: in_ready = 1; out_valid = 0, out_product = 0, out_timeout = 0; mul_start = 0, mul_data = 0; busy = 0.
- Reset mid-operation aborts silently and produces no result. Any later mul_done from the core is ignored until the next WAIT.
- Core bus protocol, in cycles relative to the START cycle c:
  - c: mul_start = 1, mul_data = A
  - c+1: mul_data = A (core loads A at the end of this cycle)
  - c+2: mul_data = B (core loads B)
  - c+3 onward: mul_data = B
- Latency, for a pair pushed at edge 0 into an empty FIFO with an idle FSM and no held output:
  - Nonzero operands: START in cycle 1, LOADA in cycle 2, LOADB in cycle 3, WAIT from cycle 4. out_valid rises at the edge that samples mul_done = 1.
  - Zero operand: out_valid high after edge 1.
- Throughput: one operation in flight. A second queued pair leaves IDLE on the edge after the first result's handshake.
- Watchdog: 17-bit counter for the default TIMEOUT; cleared on entry to WAIT.

## Test plan
- 5 × 3 with a core model raising done 5 cycles into WAIT: bus shows 5, 5, 3, 3…; out_product = 15, out_timeout = 0; mul_start high exactly 1 cycle.
- a = 0, b = 9 and a = 7, b = 0: out_product = 0 one cycle after pop; mul_start never asserts.
- Push 3 pairs back-to-back while the core is busy and out_ready = 0: in_ready drops after 2 pushes and the third is held; after draining, results appear in order with correct products (e.g. 2×2 = 4, 3×4 = 12, 6×7 = 42).
- Hold out_ready low for 10 cycles with out_valid high: out_product stays constant, no new START occurs, and the FIFO retains its entries.
- TIMEOUT = 20 with a core that never raises done: out_valid after 20 WAIT cycles with out_timeout = 1 and out_product = 0; the next pair proceeds normally.
- Assert rst_n low during WAIT, then release and raise mul_done: no out_valid; the next pushed pair produces a correct result.

Source files
------------

// File: rtl/mul_sequencer.sv
// Purpose : front-end sequencer for the repeated-addition multiplier core; queues
//           {a,b} pairs in a 2-entry FIFO, runs the core start/bus protocol and
//           returns the truncated product. Zero operands skip the core, and a
//           watchdog turns a hung core into a flagged zero result.
// Latency : nonzero pair -> START 1 cycle after push, WAIT from cycle 4, result on
//           the edge that samples mul_done; zero pair -> result 1 cycle after push.
// Backpr. : in_ready = FIFO not full (count only); out_valid is held until
//           out_ready, and no new operation leaves IDLE while a result is held.
// Ports   : clk/rst_n (async active-low); in_valid/in_ready/in_a/in_b operand
//           input; out_valid/out_ready/out_product/out_timeout result output;
//           mul_start/mul_data/mul_done/mul_product core interface; busy status.
module mul_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 70000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_product,
    output logic         out_timeout,
    output logic         mul_start,
    output logic [W-1:0] mul_data,
    input  logic         mul_done,
    input  logic [W-1:0] mul_product,
    output logic         busy
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOADA,
        S_LOADB,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    // operand FIFO
    logic [W-1:0]    r_fifo_a [2];
    logic [W-1:0]    r_fifo_b [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;

    // operation registers
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [WD_W-1:0] r_wd;

    // result register
    logic            r_out_valid;
    logic [W-1:0]    r_out_product;
    logic            r_out_timeout;

    logic            w_push;
    logic            w_pop;
    logic [W-1:0]    w_head_a;
    logic [W-1:0]    w_head_b;
    logic            w_res_load;
    logic [W-1:0]    w_res_product;
    logic            w_res_timeout;
    logic            w_mul_start;
    logic [W-1:0]    w_mul_data;

    assign in_ready = (r_count < 2'd2);
    assign w_push   = in_valid && in_ready;
    assign w_head_a = r_fifo_a[r_rd_ptr];
    assign w_head_b = r_fifo_b[r_rd_ptr];

    // ---------------------------------------------------------------- FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------ next state / control
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_res_load    = 1'b0;
        w_res_product = '0;
        w_res_timeout = 1'b0;
        w_mul_start   = 1'b0;
        w_mul_data    = '0;
        case (r_state)
            S_IDLE: begin
                // A held result blocks the pop, so a handshake edge never
                // coincides with the start of the next operation.
                if ((r_count != 2'd0) && !r_out_valid) begin
                    w_pop = 1'b1;
                    if ((w_head_a == '0) || (w_head_b == '0)) begin
                        w_res_load = 1'b1;
                    end else begin
                        w_next_state = S_START;
                    end
                end
            end
            S_START: begin
                w_mul_start  = 1'b1;
                w_mul_data   = r_a;
                w_next_state = S_LOADA;
            end
            S_LOADA: begin
                w_mul_data   = r_a;
                w_next_state = S_LOADB;
            end
            S_LOADB: begin
                w_mul_data   = r_b;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_mul_data = r_b;
                // done is checked first so it wins over a coincident timeout
                if (mul_done) begin
                    w_res_load    = 1'b1;
                    w_res_product = mul_product;
                    w_next_state  = S_IDLE;
                end else if (r_wd == WD_LAST) begin
                    w_res_load    = 1'b1;
                    w_res_timeout = 1'b1;
                    w_next_state  = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign mul_start = w_mul_start;
    assign mul_data  = w_mul_data;

    // --------------------------------------------------------------- FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_a[i] <= '0;
                r_fifo_b[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_a[r_wr_ptr] <= in_a;
                r_fifo_b[r_wr_ptr] <= in_b;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // --------------------------------------------- operands and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_wd <= '0;
        end else begin
            if (w_pop) begin
                r_a <= w_head_a;
                r_b <= w_head_b;
            end
            // Held at zero outside WAIT, so it is always 0 on entry. WAIT is
            // left when it reaches WD_LAST, so it never wraps.
            if (r_state == S_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
        end
    end

    // ------------------------------------------------------------ result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_timeout <= 1'b0;
        end else begin
            // A load is only possible with out_valid low, so it cannot
            // collide with a handshake.
            if (w_res_load) begin
                r_out_valid   <= 1'b1;
                r_out_product <= w_res_product;
                r_out_timeout <= w_res_timeout;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_timeout = r_out_timeout;
    assign busy        = (r_state != S_IDLE) || (r_count != 2'd0) || r_out_valid;

endmodule

// File: tb/tb_mul_sequencer.sv
// Purpose : self-checking bench for mul_sequencer with a small core model.
// Latency : the core model raises done 5 cycles into WAIT unless told to hang.
// Backpr. : out_ready is driven by the bench to hold or consume results.
module tb_mul_sequencer;

    localparam int W  = 16;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_product;
    logic         out_timeout;
    logic         mul_start;
    logic [W-1:0] mul_data;
    logic         mul_done;
    logic [W-1:0] mul_product;
    logic         busy;

    always #5 clk = ~clk;

    mul_sequencer #(.W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_timeout(out_timeout),
        .mul_start  (mul_start),
        .mul_data   (mul_data),
        .mul_done   (mul_done),
        .mul_product(mul_product),
        .busy       (busy)
    );

    // ------------------------------------------------------- core model
    int           phase;
    int           cnt;
    logic [W-1:0] cap_a;
    logic [W-1:0] cap_b;
    logic         model_done;
    logic [W-1:0] model_prod;
    logic         hang = 1'b0;
    logic         force_done = 1'b0;
    int           start_cnt = 0;

    assign mul_done    = model_done | force_done;
    assign mul_product = model_prod;

    function automatic logic [W-1:0] trunc_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 0;
            cnt        <= 0;
            cap_a      <= '0;
            cap_b      <= '0;
            model_done <= 1'b0;
            model_prod <= '0;
        end else if (mul_start) begin
            phase      <= 1;
            model_done <= 1'b0;
        end else if (phase == 1) begin
            cap_a <= mul_data;
            phase <= 2;
        end else if (phase == 2) begin
            cap_b <= mul_data;
            cnt   <= 0;
            phase <= 3;
        end else if (phase == 3 && !hang) begin
            if (cnt == 4) begin
                model_done <= 1'b1;
                model_prod <= trunc_mul(cap_a, cap_b);
                phase      <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (mul_start) start_cnt <= start_cnt + 1;
    end

    // ------------------------------------------------------- check helpers
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        bit done_push;
        done_push = 1'b0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        for (int k = 0; k < 200; k++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                done_push = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!done_push) chk("push_accept", 32'd0, 32'd1);
    endtask

    // Waits for out_valid; returns the number of edges waited (0 on expiry).
    task automatic wait_valid(input string name, output int n);
        n = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (out_valid) begin
                n = k;
                break;
            end
        end
        if (n == 0) chk({name, "_wait"}, 32'd0, 32'd1);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_hs_clear"}, 32'(out_valid), 32'd0);
    endtask

    task automatic get_result(input string name, input logic [W-1:0] exp_p);
        int n;
        if (!out_valid) wait_valid(name, n);
        chk({name, "_prod"}, 32'(out_product), 32'(exp_p));
        chk({name, "_to"}, 32'(out_timeout), 32'd0);
        handshake(name);
    endtask

    // ------------------------------------------------------- vector table
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        bit           zero;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        int n;
        int s0;
        logic [W-1:0] held;
        bit stable;

        vecs[0] = '{a: 16'd0,     b: 16'd9,   p: 16'd0,      zero: 1'b1};
        vecs[1] = '{a: 16'd7,     b: 16'd0,   p: 16'd0,      zero: 1'b1};
        vecs[2] = '{a: 16'd2,     b: 16'd2,   p: 16'd4,      zero: 1'b0};
        vecs[3] = '{a: 16'd3,     b: 16'd4,   p: 16'd12,     zero: 1'b0};
        vecs[4] = '{a: 16'd6,     b: 16'd7,   p: 16'd42,     zero: 1'b0};
        vecs[5] = '{a: 16'hFFFF,  b: 16'd2,   p: 16'hFFFE,   zero: 1'b0};
        vecs[6] = '{a: 16'd300,   b: 16'd300, p: 16'd24464,  zero: 1'b0};
        vecs[7] = '{a: 16'd1,     b: 16'd1,   p: 16'd1,      zero: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #2;
        // ---- reset values
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_out_prod",  32'(out_product), 32'd0);
        chk("rst_out_to",    32'(out_timeout), 32'd0);
        chk("rst_mul_start", 32'(mul_start),   32'd0);
        chk("rst_mul_data",  32'(mul_data),    32'd0);
        chk("rst_busy",      32'(busy),        32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- 5 x 3: bus sequence and single start pulse
        s0 = start_cnt;
        push(16'd5, 16'd3);
        chk("seq_idle_data", 32'(mul_data), 32'd0);
        tick();
        chk("seq_c_start", 32'(mul_start), 32'd1);
        chk("seq_c_data",  32'(mul_data),  32'd5);
        tick();
        chk("seq_c1_start", 32'(mul_start), 32'd0);
        chk("seq_c1_data",  32'(mul_data),  32'd5);
        tick();
        chk("seq_c2_data",  32'(mul_data),  32'd3);
        tick();
        chk("seq_c3_data",  32'(mul_data),  32'd3);
        chk("seq_c3_busy",  32'(busy),      32'd1);
        wait_valid("seq", n);
        // done rises at edge 9 after the push edge; out_valid at edge 10
        chk("seq_lat", 32'(n + 4), 32'd10);
        chk("seq_starts", 32'(start_cnt - s0), 32'd1);
        get_result("seq", 16'd15);
        chk("seq_busy_after", 32'(busy), 32'd0);

        // ---- table-driven vectors
        for (int i = 0; i < NV; i++) begin
            s0 = start_cnt;
            push(vecs[i].a, vecs[i].b);
            wait_valid("vec", n);
            chk("vec_lat", 32'(n), vecs[i].zero ? 32'd1 : 32'd10);
            chk("vec_starts", 32'(start_cnt - s0), vecs[i].zero ? 32'd0 : 32'd1);
            get_result("vec", vecs[i].p);
        end

        // ---- queueing, backpressure and in-order drain
        push(16'd2, 16'd2);
        tick();
        tick();
        push(16'd3, 16'd4);
        chk("q_ready_after_1", 32'(in_ready), 32'd1);
        push(16'd6, 16'd7);
        chk("q_ready_after_2", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_a     = 16'd9;
        in_b     = 16'd9;
        wait_valid("q_first", n);
        s0     = start_cnt;
        held   = out_product;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_product !== held || !out_valid || in_ready) stable = 1'b0;
        end
        chk("q_hold_stable", 32'(stable), 32'd1);
        chk("q_hold_prod",   32'(held),   32'd4);
        chk("q_hold_nostart", 32'(start_cnt - s0), 32'd0);
        handshake("q_first");
        chk("q_hs_nostart", 32'(mul_start), 32'd0);
        tick();
        chk("q_next_start", 32'(mul_start), 32'd1);
        chk("q_next_data",  32'(mul_data),  32'd3);
        push(16'd9, 16'd9);
        get_result("q_2", 16'd12);
        get_result("q_3", 16'd42);
        get_result("q_4", 16'd81);

        // ---- watchdog on a hung core
        hang = 1'b1;
        push(16'd3, 16'd5);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (out_valid) begin
                n = k;
                break;
            end
        end
        chk("wd_lat",  32'(n),           32'd24);
        chk("wd_to",   32'(out_timeout), 32'd1);
        chk("wd_prod", 32'(out_product), 32'd0);
        handshake("wd");
        hang = 1'b0;
        push(16'd4, 16'd4);
        get_result("wd_next", 16'd16);

        // ---- reset in WAIT, then a stray done
        hang = 1'b1;
        push(16'd5, 16'd5);
        for (int k = 0; k < 6; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data",  32'(mul_data),  32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        chk("mrst_ready", 32'(in_ready),  32'd1);
        tick();
        tick();
        rst_n      = 1'b1;
        hang       = 1'b0;
        force_done = 1'b1;
        s0         = start_cnt;
        stable     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid || busy) stable = 1'b0;
        end
        chk("mrst_no_result", 32'(stable), 32'd1);
        chk("mrst_no_start",  32'(start_cnt - s0), 32'd0);
        force_done = 1'b0;
        push(16'd6, 16'd5);
        get_result("mrst_next", 16'd30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
